lcd_morse_writer: RTL
=====================

// Module: lcd_morse_writer
// PURPOSE
//  Downstream consumer of the Morse RX decoder's 40-bit display buffer (8 x 5-bit codes).
//  Initialises an HD44780-compatible 16x2 LCD (8-bit bus, write-only) and mirrors the buffer
//  as 8 ASCII characters on line 1.
//  Redraws only when the buffer content differs from the last frame written.
// PARAMETERS
//  P_POWERUP   750000  cycles held idle after reset before first command (15 ms @ 50 MHz)
//  P_SETUP     4       cycles RS/DATA stable with EN low before EN rises
//  P_EN_HIGH   16      cycles EN held high per byte
//  P_CMD_WAIT  2500    cycles wait after EN falls, every byte except clear (50 us)
//  P_CLR_WAIT  100000  cycles wait after EN falls for clear command 0x01 (2 ms)
//  P_COL       4       first column on line 1; DDRAM address = 0x80 + P_COL (0..8)
// PORTS
//  iCLK          in   1   system clock
//  iRST          in   1   asynchronous reset, active-high
//  iDisplayData  in   40  8 codes; [39:35] oldest -> column P_COL, [4:0] newest -> column P_COL+7
//  oLCD_DATA     out  8   LCD data bus
//  oLCD_RS       out  1   0 = command, 1 = character data
//  oLCD_RW       out  1   always 0 (write-only)
//  oLCD_EN       out  1   LCD enable strobe
//  oLCD_ON       out  1   LCD power; 0 in reset, 1 otherwise
//  oBusy         out  1   1 whenever FSM is not in IDLE
//  oFrameDone    out  1   one-cycle pulse after the last character of a frame completes its wait
// BEHAVIOUR
//  Reset (async, any state): DATA=0x00, RS=0, RW=0, EN=0, ON=0, Busy=1, FrameDone=0;
//   FSM -> POWERUP, init index=0, char index=0, dirty=1, shadow=0.
//  States:
//   POWERUP: count P_POWERUP cycles -> INIT.
//   INIT: send 0x38, 0x0C, 0x01, 0x06 in order (RS=0) via the byte-write sequence -> IDLE.
//   IDLE: if dirty OR iDisplayData != shadow: latch shadow <= iDisplayData, clear dirty -> ADDR.
//   ADDR: send command 0x80+P_COL (RS=0) -> CHAR.
//   CHAR: send 8 data bytes (RS=1), shadow[39:35] first through shadow[4:0] last -> DONE.
//   DONE: pulse oFrameDone for 1 cycle -> IDLE.
//  Byte-write sequence: DATA/RS driven at phase entry; SETUP phase (EN=0) P_SETUP cycles;
//   EN=1 for P_EN_HIGH cycles; then EN=0 WAIT phase, P_CLR_WAIT cycles if byte is 0x01 with
//   RS=0, else P_CMD_WAIT. DATA/RS stay stable through EN fall and hold while WAIT runs.
//  Per-byte duration = P_SETUP + P_EN_HIGH + wait cycles (exact, +/-0); no EN glitches.
//  Code -> ASCII: 0..25 -> 0x41+code ('A'..'Z'); 31 -> 0x20 (space); 26..30 -> 0x3F ('?').
//  Conversion is combinational on the shadow copy; iDisplayData is sampled only in IDLE.
//  Input changes during a frame are ignored until IDLE; then any difference starts one new frame.
//  Several changes during one frame produce exactly one follow-up frame with the latest value.
//  First frame after init always runs (dirty=1), even if iDisplayData equals 0.
//  ON=1 from the first clock after reset deassertion; oLCD_RW is constant 0.
//  Counters are sized for the largest parameter; no counter wraps inside a phase.
//  Reset mid-frame: EN drops to 0 immediately and the full power-up/init sequence repeats.
// TESTING
//  (Bench parameters: P_POWERUP=20, P_SETUP=2, P_EN_HIGH=3, P_CMD_WAIT=5, P_CLR_WAIT=12, P_COL=4.)
//  T1 Reset then 40'hFFFFFFFFFF -> EN high-pulses carry 0x38, 0x0C, 0x01, 0x06, 0x84,
//     then eight 0x20 bytes with RS=1; one FrameDone pulse; Busy=0 afterwards.
//  T2 Timing: first EN rise exactly 20+2 cycles after reset release; EN high 3 cycles;
//     gap from EN fall to next EN rise = 5+2 cycles (12+2 after 0x01).
//  T3 Input {0,1,2,3,4,5,25,31} -> data bytes 'A','B','C','D','E','F','Z',' ' in that order
//     after address 0x84; codes 26 and 30 -> 0x3F.
//  T4 Unchanged input held for 1000 cycles after a frame -> no EN activity, Busy stays 0.
//  T5 Three input changes during one frame -> exactly one further frame, showing the last value.
//  T6 iRST asserted during the 5th character's EN-high -> EN=0 and ON=0 within the same cycle;
//     after release, the full init and frame sequence repeats.

Source files
------------

// File: rtl/lcd_morse_writer.sv
// HD44780 16x2 writer: power-up and init sequence, then mirrors the 8-code Morse display
// buffer as ASCII on line 1, redrawing only when the buffer content changes.
module lcd_morse_writer #(
  parameter int unsigned P_POWERUP  = 750000,
  parameter int unsigned P_SETUP    = 4,
  parameter int unsigned P_EN_HIGH  = 16,
  parameter int unsigned P_CMD_WAIT = 2500,
  parameter int unsigned P_CLR_WAIT = 100000,
  parameter int unsigned P_COL      = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [39:0] iDisplayData,
  output logic [7:0]  oLCD_DATA,
  output logic        oLCD_RS,
  output logic        oLCD_RW,
  output logic        oLCD_EN,
  output logic        oLCD_ON,
  output logic        oBusy,
  output logic        oFrameDone
);

  localparam int unsigned M1    = (P_POWERUP > P_CLR_WAIT) ? P_POWERUP : P_CLR_WAIT;
  localparam int unsigned M2    = (P_CMD_WAIT > P_EN_HIGH) ? P_CMD_WAIT : P_EN_HIGH;
  localparam int unsigned M3    = (M2 > P_SETUP) ? M2 : P_SETUP;
  localparam int unsigned P_MAX = (M1 > M3) ? M1 : M3;
  localparam int unsigned CW    = $clog2(P_MAX + 1);

  typedef enum logic [2:0] {S_POWERUP, S_INIT, S_IDLE, S_ADDR, S_CHAR, S_DONE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_t;

  state_t        state, state_d;
  phase_t        phase, phase_d;
  logic [CW-1:0] cnt, cnt_d, wait_last;
  logic [2:0]    idx, idx_d;
  logic          dirty, dirty_d;
  logic [39:0]   shadow, shadow_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d, en_q, en_d, on_q;
  logic          load, byte_done;

  function automatic logic [7:0] to_ascii(input logic [4:0] code);
    if (code < 5'd26)      return 8'h41 + {3'b000, code};
    else if (code == 5'd31) return 8'h20;
    else                   return 8'h3F;
  endfunction

  // {rs, data} of the byte that state/index select; used when a byte is first loaded
  function automatic logic [8:0] byte_for(input state_t st, input logic [2:0] ix,
                                          input logic [39:0] shd);
    logic [5:0] lsb;
    lsb = 6'(3'd7 - ix) * 6'd5;
    case (st)
      S_INIT: begin
        case (ix)
          3'd0:    return {1'b0, 8'h38};
          3'd1:    return {1'b0, 8'h0C};
          3'd2:    return {1'b0, 8'h01};
          default: return {1'b0, 8'h06};
        endcase
      end
      S_ADDR:  return {1'b0, 8'h80 + 8'(P_COL)};
      S_CHAR:  return {1'b1, to_ascii(shd[lsb +: 5])};
      default: return 9'h000;
    endcase
  endfunction

  always_comb begin
    wait_last = (!rs_q && data_q == 8'h01) ? CW'(P_CLR_WAIT - 1) : CW'(P_CMD_WAIT - 1);
  end

  always_comb begin
    state_d   = state;
    phase_d   = phase;
    cnt_d     = cnt;
    idx_d     = idx;
    dirty_d   = dirty;
    shadow_d  = shadow;
    data_d    = data_q;
    rs_d      = rs_q;
    en_d      = 1'b0;
    load      = 1'b0;
    byte_done = 1'b0;

    case (state)
      S_POWERUP: begin
        if (cnt == CW'(P_POWERUP - 1)) begin
          state_d = S_INIT;
          idx_d   = '0;
          cnt_d   = '0;
          phase_d = PH_SETUP;
          load    = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_INIT, S_ADDR, S_CHAR: begin
        case (phase)
          PH_SETUP: begin
            if (cnt == CW'(P_SETUP - 1)) begin
              phase_d = PH_EN;
              cnt_d   = '0;
              en_d    = 1'b1;
            end else begin
              cnt_d = cnt + CW'(1);
            end
          end
          PH_EN: begin
            if (cnt == CW'(P_EN_HIGH - 1)) begin
              phase_d = PH_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt + CW'(1);
              en_d  = 1'b1;
            end
          end
          default: begin
            if (cnt == wait_last) begin
              byte_done = 1'b1;
              cnt_d     = '0;
              phase_d   = PH_SETUP;
            end else begin
              cnt_d = cnt + CW'(1);
            end
          end
        endcase

        if (byte_done) begin
          case (state)
            S_INIT: begin
              if (idx == 3'd3) begin
                state_d = S_IDLE;
              end else begin
                idx_d = idx + 3'd1;
                load  = 1'b1;
              end
            end
            S_ADDR: begin
              state_d = S_CHAR;
              idx_d   = '0;
              load    = 1'b1;
            end
            default: begin
              if (idx == 3'd7) begin
                state_d = S_DONE;
              end else begin
                idx_d = idx + 3'd1;
                load  = 1'b1;
              end
            end
          endcase
        end
      end
      S_IDLE: begin
        if (dirty || iDisplayData != shadow) begin
          shadow_d = iDisplayData;
          dirty_d  = 1'b0;
          state_d  = S_ADDR;
          phase_d  = PH_SETUP;
          cnt_d    = '0;
          load     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      {rs_d, data_d} = byte_for(state_d, idx_d, shadow_d);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state  <= S_POWERUP;
      phase  <= PH_SETUP;
      cnt    <= '0;
      idx    <= '0;
      dirty  <= 1'b1;
      shadow <= '0;
      data_q <= '0;
      rs_q   <= 1'b0;
      en_q   <= 1'b0;
      on_q   <= 1'b0;
    end else begin
      state  <= state_d;
      phase  <= phase_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      dirty  <= dirty_d;
      shadow <= shadow_d;
      data_q <= data_d;
      rs_q   <= rs_d;
      en_q   <= en_d;
      on_q   <= 1'b1;
    end
  end

  assign oLCD_DATA  = data_q;
  assign oLCD_RS    = rs_q;
  assign oLCD_RW    = 1'b0;
  assign oLCD_EN    = en_q;
  assign oLCD_ON    = on_q;
  assign oBusy      = (state != S_IDLE);
  assign oFrameDone = (state == S_DONE);

endmodule
